// File: rtl/bf16_result_drain.sv
// Snapshots a row of BF16 PE results on capture, clears the PEs, and streams each column
// out as FP8 E4M3 (RNE, saturating, FTZ) over valid/ready. Build macro DRAIN_RELU_EN zeroes negatives.
module bf16_result_drain #(
  parameter int NUM_COLS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_COLS*16-1:0]      res_in,
  input  logic                        capture,
  output logic                        pe_clear,
  output logic                        busy,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [7:0]                  out_data,
  output logic [$clog2(NUM_COLS)-1:0] out_idx,
  output logic                        out_last,
  output logic                        done
);

  localparam int IDX_W = $clog2(NUM_COLS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COLS - 1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t           r_state;
  logic [15:0]      r_buf [NUM_COLS];
  logic [IDX_W-1:0] r_cnt;
  logic             r_pe_clear;
  logic             r_busy;
  logic             r_out_valid;
  logic             r_done;
  logic [7:0]       w_cvt;

  function automatic logic [7:0] cvt(input logic [15:0] x);
    logic              s;
    logic [7:0]        e;
    logic [6:0]        m;
    logic signed [8:0] e8;
    logic              rnd;
    logic [3:0]        m4;
    logic [7:0]        r;
    s   = x[15];
    e   = x[14:7];
    m   = x[6:0];
    e8  = $signed({1'b0, e}) - 9'sd120;
    rnd = m[3] && ((|m[2:0]) || m[4]);
    m4  = {1'b0, m[6:4]} + {3'b000, rnd};
    if (m4[3]) e8 = e8 + 9'sd1;
    r = {s, e8[3:0], m4[2:0]};
    if (e == 8'd0) r = 8'h00;
    else if (e == 8'hFF) r = {s, 7'h7E};
    else if ((e8 > 9'sd15) || ((e8 == 9'sd15) && (m4[2:0] == 3'd7))) r = {s, 7'h7E};
    else if (e8 < 9'sd1) r = 8'h00;
`ifdef DRAIN_RELU_EN
    // Negative inputs of every class (including -0, -Inf, NaN) clamp to +0.
    if (s) r = 8'h00;
`endif
    return r;
  endfunction

  assign w_cvt = cvt(r_buf[r_cnt]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_pe_clear  <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      for (int k = 0; k < NUM_COLS; k++) r_buf[k] <= 16'h0000;
    end else begin
      r_pe_clear <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (capture) begin
            for (int k = 0; k < NUM_COLS; k++) r_buf[k] <= res_in[16*k +: 16];
            r_cnt       <= '0;
            r_state     <= S_STREAM;
            r_busy      <= 1'b1;
            r_out_valid <= 1'b1;
            r_pe_clear  <= 1'b1;
          end
        end
        S_STREAM: begin
          // Captures here are dropped, including one coinciding with the final handshake.
          if (out_ready) begin
            if (r_cnt == LAST_IDX) begin
              r_state     <= S_IDLE;
              r_cnt       <= '0;
              r_busy      <= 1'b0;
              r_out_valid <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_cnt <= r_cnt + IDX_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pe_clear  = r_pe_clear;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign done      = r_done;
  assign out_idx   = r_cnt;
  assign out_data  = r_out_valid ? w_cvt : 8'h00;
  assign out_last  = r_out_valid && (r_cnt == LAST_IDX);

endmodule

// File: tb/tb_bf16_result_drain.sv
// Bench for bf16_result_drain: conversion vectors streamed through snapshots, with a
// scoreboard on every handshake plus backpressure, busy-capture and mid-stream reset sequences.
module tb_bf16_result_drain;

  localparam int NC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] res_in = '0;
  logic        capture = 1'b0;
  logic        out_ready = 1'b1;
  logic        pe_clear, busy, out_valid, out_last, done;
  logic [7:0]  out_data;
  logic [1:0]  out_idx;

  bf16_result_drain #(.NUM_COLS(NC)) dut (
    .clk(clk), .rst_n(rst_n), .res_in(res_in), .capture(capture),
    .pe_clear(pe_clear), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [15:0] din; logic [7:0] dout; } vec_t;
  typedef struct packed { logic [7:0] d; logic [1:0] i; logic l; } exp_t;

  vec_t tbl [20];
  exp_t sb [$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   pe_clr_cnt = 0;
  int   done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Scoreboard: every accepted beat pops one expected record.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pe_clear) pe_clr_cnt++;
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("beat_data", out_data, mon_e.d);
          chk("beat_idx", out_idx, mon_e.i);
          chk("beat_last", out_last, mon_e.l);
        end
      end
    end
  end

  task automatic load(input int g);
    for (int k = 0; k < NC; k++) begin
      res_in[16*k +: 16] = tbl[4*g+k].din;
      sb.push_back('{d: tbl[4*g+k].dout, i: 2'(k), l: (k == NC-1)});
    end
  endtask

  task automatic run_snapshot(input int g);
    int n;
    int pc0;
    int dc0;
    pc0 = pe_clr_cnt;
    dc0 = done_cnt;
    @(posedge clk); #1;
    load(g);
    capture = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    capture = 1'b0;
    @(negedge clk);
    chk("first_valid", out_valid, 1);
    chk("first_pe_clear", pe_clear, 1);
    chk("first_idx", out_idx, 0);
    n = 1;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_cycles", n, NC + 1);
    chk("done_pulse", done, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_valid, 0);
    chk("sb_empty", sb.size(), 0);
    chk("pe_clear_once", pe_clr_cnt - pc0, 1);
    chk("done_once", done_cnt - dc0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pc0;
    int dc0;
    tbl[0]  = '{16'h3F80, 8'h38}; tbl[1]  = '{16'h4000, 8'h40};
    tbl[2]  = '{16'hBFC0, 8'hBC}; tbl[3]  = '{16'h447A, 8'h7E};
    tbl[4]  = '{16'h3F88, 8'h38}; tbl[5]  = '{16'h3F98, 8'h3A};
    tbl[6]  = '{16'h3F9C, 8'h3A}; tbl[7]  = '{16'h3FF8, 8'h40};
    tbl[8]  = '{16'h3A00, 8'h00}; tbl[9]  = '{16'h3C80, 8'h08};
    tbl[10] = '{16'h43E0, 8'h7E}; tbl[11] = '{16'h43F0, 8'h7E};
    tbl[12] = '{16'hFF80, 8'hFE}; tbl[13] = '{16'h0000, 8'h00};
    tbl[14] = '{16'h8000, 8'h00}; tbl[15] = '{16'h7FC0, 8'h7E};
    tbl[16] = '{16'hBFC0, 8'hBC}; tbl[17] = '{16'h8000, 8'h00};
    tbl[18] = '{16'h3F80, 8'h38}; tbl[19] = '{16'hFF80, 8'hFE};
`ifdef DRAIN_RELU_EN
    for (int v = 0; v < 20; v++) if (tbl[v].din[15]) tbl[v].dout = 8'h00;
`endif

    #12;
    chk("rst_pe_clear", pe_clear, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_idx", out_idx, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_snapshot(0);

    // Backpressure at idx1, capture held high through the stream and the final handshake.
    pc0 = pe_clr_cnt;
    dc0 = done_cnt;
    @(posedge clk); #1;
    load(1);
    capture = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    res_in = 64'h447A_BFC0_4000_3F80;
    @(negedge clk);
    chk("bp_pe_clear", pe_clear, 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_idx_held", out_idx, 1);
      chk("bp_data_held", out_data, tbl[5].dout);
      chk("bp_valid_held", out_valid, 1);
      chk("bp_no_clear", pe_clear, 0);
      @(posedge clk);
    end
    #1;
    out_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_last && n < 20);
    chk("bp_reach_last", out_last, 1);
    @(posedge clk); #1;
    capture = 1'b0;
    @(negedge clk);
    chk("bp_done", done, 1);
    chk("bp_busy_low", busy, 0);
    chk("bp_valid_low", out_valid, 0);
    @(negedge clk);
    chk("bp_final_capture_ignored", out_valid, 0);
    chk("bp_pe_clear_once", pe_clr_cnt - pc0, 1);
    chk("bp_done_once", done_cnt - dc0, 1);
    chk("bp_sb_empty", sb.size(), 0);

    // Reset while idx2 is presented.
    dc0 = done_cnt;
    @(posedge clk); #1;
    load(2);
    capture = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    capture = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("pre_rst_idx", out_idx, 2);
    rst_n = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_idx", out_idx, 0);
    chk("mid_rst_data", out_data, 8'h00);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_pe_clear", pe_clear, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_leftover", sb.size(), 2);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("no_done_after_rst", done_cnt - dc0, 0);
    chk("idle_after_rst", busy, 0);

    run_snapshot(3);
    run_snapshot(4);

    chk("total_pe_clears", pe_clr_cnt, 5);
    chk("total_dones", done_cnt, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
